// File: rtl/ps2_device_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_device_tx
//  Description : PS/2 device-side transmitter. Emulates a keyboard/mouse and
//                shifts scancode bytes out on the open-drain PS/2 clock and
//                data lines. It generates the device clock, backs off when the
//                host inhibits the bus and retransmits the same byte.
//                Optional host-to-device receive path: define PS2_HOST_RX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_device_tx #(
    parameter int QTR_CYCLES = 1600,
    parameter int IDLE_QTRS  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_abort,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err
);

    localparam int QW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
    localparam int IW = (IDLE_QTRS > 1) ? $clog2(IDLE_QTRS) : 1;
    localparam logic [QW-1:0] c_QEND     = QW'(QTR_CYCLES - 1);
    localparam logic [IW-1:0] c_IEND     = IW'(IDLE_QTRS - 1);
    localparam logic [3:0]    c_LAST_BIT = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLDOFF = 2'd1,
        S_SEND    = 2'd2,
        S_RECV    = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [QW-1:0]   r_qcnt, w_qcnt_nxt, w_qcnt_inc;
    logic [1:0]      r_qtr, w_qtr_nxt;
    logic [3:0]      r_bit, w_bit_nxt;
    logic [IW-1:0]   r_idle, w_idle_nxt;
    logic [7:0]      r_byte, w_byte_nxt;
    logic            r_clk_m, r_clk_s, r_dat_m, r_dat_s;
    logic            r_clk_oe, r_data_oe, r_tx_ready, r_tx_done, r_tx_abort;
    logic            w_clk_oe_nxt, w_data_oe_nxt, w_done_nxt, w_abort_nxt;
    logic            w_qend, w_active;
    logic [10:0]     w_frame;

    // Bit 0 is the start bit; parity makes the data+parity ones count odd.
    assign w_frame    = {1'b1, ~^r_byte, r_byte, 1'b0};
    assign w_qend     = (r_qcnt == c_QEND);
    assign w_qcnt_inc = w_qend ? '0 : r_qcnt + 1'b1;

`ifdef PS2_HOST_RX_EN
    logic            r_pend, w_pend_nxt;
    logic [9:0]      r_shift, w_shift_nxt;
    logic [7:0]      r_rx_data, w_rx_data_nxt;
    logic            r_rx_valid, r_rx_err, w_rx_valid_nxt, w_rx_err_nxt;
    logic [QW-1:0]   r_low_cnt;
    logic            r_rts_arm;
    logic            w_rts, w_rx_ok;

    // Request-to-send: data low with clock high after a long enough clock-low.
    assign w_rts   = ((r_state == S_IDLE) || (r_state == S_HOLDOFF)) &&
                     r_clk_s && !r_dat_s && r_rts_arm;
    // After ten samples r_shift holds {stop, parity, data[7:0]}.
    assign w_rx_ok = (^r_shift[8:0]) && r_shift[9];

    // Arm request-to-send once the host held clock low for a full quarter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_low_cnt <= '0;
            r_rts_arm <= 1'b0;
        end else if ((r_state == S_IDLE) || (r_state == S_HOLDOFF)) begin
            if (!r_clk_s) begin
                if (r_low_cnt == c_QEND) r_rts_arm <= 1'b1;
                else                     r_low_cnt <= r_low_cnt + 1'b1;
            end else begin
                r_low_cnt <= '0;
                if (r_dat_s) r_rts_arm <= 1'b0;
            end
        end else begin
            r_low_cnt <= '0;
            r_rts_arm <= 1'b0;
        end
    end
`endif

    // Two-flop synchronisers for the asynchronous bus lines.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_m <= 1'b1;
            r_clk_s <= 1'b1;
            r_dat_m <= 1'b1;
            r_dat_s <= 1'b1;
        end else begin
            r_clk_m <= ps2_clk_in;
            r_clk_s <= r_clk_m;
            r_dat_m <= ps2_data_in;
            r_dat_s <= r_dat_m;
        end
    end

    // Next-state, counters and output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_qtr_nxt   = r_qtr;
        w_bit_nxt   = r_bit;
        w_idle_nxt  = r_idle;
        w_byte_nxt  = r_byte;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
`ifdef PS2_HOST_RX_EN
        w_pend_nxt     = r_pend;
        w_shift_nxt    = r_shift;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_rx_err_nxt   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_qcnt_nxt = '0;
                w_qtr_nxt  = '0;
                w_bit_nxt  = '0;
                w_idle_nxt = '0;
                if (tx_valid && r_tx_ready) begin
                    w_byte_nxt  = tx_data;
                    w_state_nxt = S_HOLDOFF;
`ifdef PS2_HOST_RX_EN
                    w_pend_nxt  = 1'b1;
`endif
                end
`ifdef PS2_HOST_RX_EN
                // Host request wins over a byte offered the same cycle.
                if (w_rts) w_state_nxt = S_RECV;
`endif
            end
            S_HOLDOFF: begin
                w_qtr_nxt = '0;
                w_bit_nxt = '0;
                if (!(r_clk_s && r_dat_s)) begin
                    w_qcnt_nxt = '0;
                    w_idle_nxt = '0;
                end else begin
                    w_qcnt_nxt = w_qcnt_inc;
                    if (w_qend) begin
                        if (r_idle == c_IEND) begin
                            w_idle_nxt  = '0;
                            w_state_nxt = S_SEND;
                        end else begin
                            w_idle_nxt = r_idle + 1'b1;
                        end
                    end
                end
`ifdef PS2_HOST_RX_EN
                if (w_rts) begin
                    w_state_nxt = S_RECV;
                    w_qcnt_nxt  = '0;
                    w_idle_nxt  = '0;
                end
`endif
            end
            S_SEND: begin
                w_qcnt_nxt = w_qcnt_inc;
                if (w_qend) begin
                    w_qtr_nxt = r_qtr + 2'd1;
                    if (r_qtr == 2'd3) begin
                        if (r_bit == c_LAST_BIT) begin
                            w_state_nxt = S_IDLE;
                            w_bit_nxt   = '0;
                            w_done_nxt  = 1'b1;
`ifdef PS2_HOST_RX_EN
                            w_pend_nxt  = 1'b0;
`endif
                        end else begin
                            w_bit_nxt = r_bit + 4'd1;
                        end
                    end else if ((r_qtr == 2'd1) && (r_bit != c_LAST_BIT) && !r_clk_s) begin
                        // Clock is ours to release here, so a low level is the host.
                        w_abort_nxt = 1'b1;
                        w_state_nxt = S_HOLDOFF;
                        w_qtr_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_idle_nxt  = '0;
                    end
                end
            end
`ifdef PS2_HOST_RX_EN
            S_RECV: begin
                w_qcnt_nxt = w_qcnt_inc;
                if (w_qend) begin
                    w_qtr_nxt = r_qtr + 2'd1;
                    if ((r_qtr == 2'd1) && (r_bit != c_LAST_BIT))
                        w_shift_nxt = {r_dat_s, r_shift[9:1]};
                    if (r_qtr == 2'd3) begin
                        if (r_bit == c_LAST_BIT) begin
                            w_state_nxt = r_pend ? S_HOLDOFF : S_IDLE;
                            w_bit_nxt   = '0;
                            w_idle_nxt  = '0;
                            if (w_rx_ok) begin
                                w_rx_valid_nxt = 1'b1;
                                w_rx_data_nxt  = r_shift[7:0];
                            end else begin
                                w_rx_err_nxt = 1'b1;
                            end
                        end else begin
                            w_bit_nxt = r_bit + 4'd1;
                        end
                    end
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line drives follow the next state so they change together with it.
    assign w_active      = (w_state_nxt == S_SEND) || (w_state_nxt == S_RECV);
    assign w_clk_oe_nxt  = w_active && w_qtr_nxt[1];
    assign w_data_oe_nxt = ((w_state_nxt == S_SEND) && !w_frame[w_bit_nxt]) ||
                           ((w_state_nxt == S_RECV) && (w_bit_nxt == c_LAST_BIT));

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_qcnt     <= '0;
            r_qtr      <= '0;
            r_bit      <= '0;
            r_idle     <= '0;
            r_byte     <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_ready <= 1'b1;
            r_tx_done  <= 1'b0;
            r_tx_abort <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_qcnt     <= w_qcnt_nxt;
            r_qtr      <= w_qtr_nxt;
            r_bit      <= w_bit_nxt;
            r_idle     <= w_idle_nxt;
            r_byte     <= w_byte_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_tx_ready <= (w_state_nxt == S_IDLE);
            r_tx_done  <= w_done_nxt;
            r_tx_abort <= w_abort_nxt;
        end
    end

`ifdef PS2_HOST_RX_EN
    // Receive-side registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend     <= 1'b0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_shift    <= w_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_err   <= w_rx_err_nxt;
        end
    end

    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign rx_err   = r_rx_err;
`else
    assign rx_valid = 1'b0;
    assign rx_data  = 8'h00;
    assign rx_err   = 1'b0;
`endif

    assign tx_ready    = r_tx_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_done     = r_tx_done;
    assign tx_abort    = r_tx_abort;

endmodule
`default_nettype wire

// File: tb/tb_ps2_device_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_device_tx
//  Description : Self-checking bench for ps2_device_tx with a host-side line
//                model and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_device_tx;

    localparam int c_QTR       = 4;
    localparam int c_IDLE      = 2;
    localparam int c_FRAME_CYC = 44 * c_QTR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_abort;
    logic       rx_valid, rx_err;
    logic [7:0] rx_data;
    logic       host_clk_low = 1'b0;
    logic       host_data_low = 1'b0;
    logic       w_line_clk, w_line_data;

    // Open-drain bus: either side may pull low.
    assign w_line_clk  = ~ps2_clk_oe & ~host_clk_low;
    assign w_line_data = ~ps2_data_oe & ~host_data_low;

    ps2_device_tx #(.QTR_CYCLES(c_QTR), .IDLE_QTRS(c_IDLE)) u_dut (
        .clock       (clk),
        .reset       (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (w_line_clk),
        .ps2_data_in (w_line_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_done     (tx_done),
        .tx_abort    (tx_abort),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_err      (rx_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: what a host sees on its 11 falling clock edges.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        par = (ones % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Bus monitor: host-side sampling and event bookkeeping.
    int   cyc = 0, done_cnt = 0, abort_cnt = 0, rxv_cnt = 0, rxe_cnt = 0, ready_bad = 0;
    int   send_cyc = 0, done_cyc = 0;
    int   done_cycs[$];
    logic q_bits[$];
    logic in_frame = 1'b0, prev_lclk = 1'b1, prev_doe = 1'b0;
    logic [7:0] last_rx = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (prev_lclk && !w_line_clk) q_bits.push_back(w_line_data);
        prev_lclk = w_line_clk;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (tx_done) begin done_cnt++; done_cyc = cyc; done_cycs.push_back(cyc); in_frame = 1'b0; end
            if (tx_abort) begin abort_cnt++; in_frame = 1'b0; end
            if (rx_valid) begin rxv_cnt++; last_rx = rx_data; in_frame = 1'b0; end
            if (rx_err) begin rxe_cnt++; in_frame = 1'b0; end
            if (ps2_data_oe && !prev_doe && !in_frame) begin send_cyc = cyc; in_frame = 1'b1; end
            if (in_frame && tx_ready) ready_bad++;
        end
        prev_doe = ps2_data_oe;
    end

    task automatic wait_done(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin @(negedge clk); k++; end
        check_val(tag, done_cnt, target);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input int first);
        logic [10:0] got;
        got = '0;
        for (int i = 0; i < 11; i++)
            if (first + i < q_bits.size()) got[i] = q_bits[first + i];
        check_val({tag, "_bits"}, 32'(got), 32'(ref_frame(b)));
    endtask

    task automatic send_one(input logic [7:0] b, input string tag);
        int k;
        q_bits.delete();
        done_cnt = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 500) begin @(negedge clk); k++; end
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done(1, c_FRAME_CYC + 100, {tag, "_done"});
        repeat (3) @(negedge clk);
        check_val({tag, "_ndone"}, done_cnt, 1);
        check_val({tag, "_len"}, q_bits.size(), 11);
        check_frame(tag, b, 0);
        check_val({tag, "_lat"}, done_cyc - send_cyc, c_FRAME_CYC);
        check_val({tag, "_ready"}, 32'(tx_ready), 1);
    endtask

`ifdef PS2_HOST_RX_EN
    task automatic host_send(input logic [7:0] b, input logic par, input logic exp_ok, input string tag);
        logic [9:0] hb;
        int   k, ack;
        logic pc;
        hb = {1'b1, par, b};
        rxv_cnt = 0;
        rxe_cnt = 0;
        @(negedge clk);
        host_clk_low = 1'b1;
        repeat (8) @(negedge clk);
        host_data_low = 1'b1;
        @(negedge clk);
        host_clk_low = 1'b0;
        repeat (4) @(negedge clk);
        host_data_low = ~hb[0];
        // Host shifts the next bit while the device holds clock low.
        for (int i = 1; i <= 10; i++) begin
            k  = 0;
            pc = ps2_clk_oe;
            @(negedge clk);
            while (!(ps2_clk_oe && !pc) && k < 100) begin pc = ps2_clk_oe; @(negedge clk); k++; end
            if (i <= 9) host_data_low = ~hb[i];
            else        host_data_low = 1'b0;
        end
        ack = 0;
        k   = 0;
        while ((rxv_cnt + rxe_cnt) == 0 && k < 300) begin
            @(negedge clk);
            if (ps2_data_oe) ack++;
            k++;
        end
        repeat (2) @(negedge clk);
        check_val({tag, "_ack"}, ack, 4 * c_QTR);
        check_val({tag, "_rxv"}, rxv_cnt, exp_ok ? 1 : 0);
        check_val({tag, "_rxe"}, rxe_cnt, exp_ok ? 0 : 1);
        if (exp_ok) check_val({tag, "_data"}, 32'(last_rx), 32'(b));
        repeat (20) @(negedge clk);
    endtask
`endif

    initial begin
        int k, rel;
        logic [7:0] rb;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(tx_ready), 1);
        check_val("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check_val("rst_data_oe", 32'(ps2_data_oe), 0);
        check_val("rst_done", 32'(tx_done), 0);
        check_val("rst_abort", 32'(tx_abort), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Directed frames
        send_one(8'h1C, "f1c");
        send_one(8'h00, "f00");
        send_one(8'hFF, "fff");

        // Randomized frames with random idle gaps
        for (int n = 0; n < 6; n++) begin
            rb = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_one(rb, "rand");
        end

        // Host inhibit during bit 4, then automatic retransmission
        q_bits.delete();
        done_cnt  = 0;
        abort_cnt = 0;
        @(negedge clk);
        tx_data  = 8'h1C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        k = 0;
        while (q_bits.size() < 4 && k < 500) begin @(negedge clk); k++; end
        repeat (11) @(negedge clk);
        host_clk_low = 1'b1;
        k = 0;
        while (abort_cnt == 0 && k < 20) begin @(negedge clk); k++; end
        check_val("abort_pulse", abort_cnt, 1);
        check_val("abort_clk_oe", 32'(ps2_clk_oe), 0);
        check_val("abort_data_oe", 32'(ps2_data_oe), 0);
        repeat (40 - k) @(negedge clk);
        host_clk_low = 1'b0;
        rel = cyc;
        q_bits.delete();
        wait_done(1, c_FRAME_CYC + 200, "abort_done");
        repeat (3) @(negedge clk);
        check_val("abort_once", abort_cnt, 1);
        check_val("abort_ndone", done_cnt, 1);
        check_val("abort_len", q_bits.size(), 11);
        check_frame("abort_retx", 8'h1C, 0);
        check_val("abort_gap", 32'(send_cyc - rel >= c_IDLE * c_QTR), 1);
        check_val("abort_lat", done_cyc - send_cyc, c_FRAME_CYC);

        // Back-to-back frames with tx_valid held
        q_bits.delete();
        done_cycs.delete();
        done_cnt  = 0;
        ready_bad = 0;
        @(negedge clk);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h55;
        k = 0;
        while (!tx_ready && k < 500) begin @(negedge clk); k++; end
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done(2, 2 * c_FRAME_CYC + 200, "b2b_done");
        repeat (3) @(negedge clk);
        check_val("b2b_len", q_bits.size(), 22);
        check_frame("b2b_aa", 8'hAA, 0);
        check_frame("b2b_55", 8'h55, 11);
        check_val("b2b_ready_low", ready_bad, 0);
        if (done_cycs.size() > 0)
            check_val("b2b_gap", 32'(send_cyc - done_cycs[0] >= c_IDLE * c_QTR), 1);
        else
            check_val("b2b_gap_seen", done_cycs.size(), 1);

        // Asynchronous reset in the middle of bit 6 Q2
        q_bits.delete();
        done_cnt = 0;
        @(negedge clk);
        tx_data  = 8'h1C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        k = 0;
        while (q_bits.size() < 7 && k < 500) begin @(negedge clk); k++; end
        check_val("mid_clk_oe", 32'(ps2_clk_oe), 1);
        check_val("mid_data_oe", 32'(ps2_data_oe), 1);
        #1 rst = 1'b1;
        #1;
        check_val("arst_clk_oe", 32'(ps2_clk_oe), 0);
        check_val("arst_data_oe", 32'(ps2_data_oe), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (250) @(negedge clk);
        check_val("arst_ready", 32'(tx_ready), 1);
        check_val("arst_no_done", done_cnt, 0);
        check_val("arst_idle_clk", 32'(ps2_clk_oe), 0);

        // No receive activity has been requested so far
        check_val("rx_quiet", rxv_cnt + rxe_cnt, 0);

`ifdef PS2_HOST_RX_EN
        host_send(8'hED, 1'b1, 1'b1, "rx_ok");
        host_send(8'hED, 1'b0, 1'b0, "rx_par");
`else
        check_val("rx_data_tied", 32'(rx_data), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
